// File: rtl/cargador_operandos.sv
// Operand entry stage for the 3-bit subtractor: synchronizes and debounces a push
// button, then loads operand A, operand B, and flags the pair as complete.
module cargador_operandos #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             listo,
  output logic [1:0]       estado
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    CARGA_A  = 2'd0,
    CARGA_B  = 2'd1,
    LISTO    = 2'd2,
    INVALIDO = 2'd3
  } estado_t;

  logic             btn_p0;
  logic             btn_s;
  logic [WIDTH-1:0] sw_p0;
  logic [WIDTH-1:0] sw_s;

  logic [CW-1:0]    cnt;
  logic             btn_db;
  logic             btn_db_d;
  logic             press;

  estado_t          state;
  estado_t          state_n;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;
  logic             listo_n;

  // Stage p0/p1: two-flop synchronizers for the asynchronous button and switches
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0 <= 1'b0;
      btn_s  <= 1'b0;
      sw_p0  <= '0;
      sw_s   <= '0;
    end else begin
      btn_p0 <= btn;
      btn_s  <= btn_p0;
      sw_p0  <= sw;
      sw_s   <= sw_p0;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES stable cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    listo_n = listo;
    case (state)
      CARGA_A: begin
        if (press) begin
          a_n     = sw_s;
          state_n = CARGA_B;
        end
      end
      CARGA_B: begin
        if (press) begin
          b_n     = sw_s;
          listo_n = 1'b1;
          state_n = LISTO;
        end
      end
      LISTO: begin
        if (press) begin
          listo_n = 1'b0;
          state_n = CARGA_A;
        end
      end
      default: begin
        // Unreachable code: recover to a clean start without touching operands
        listo_n = 1'b0;
        state_n = CARGA_A;
      end
    endcase
  end

  // Output registers: a, b and listo move only on a capture edge or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CARGA_A;
      a     <= '0;
      b     <= '0;
      listo <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      listo <= listo_n;
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_cargador_operandos.sv
// Directed bench for cargador_operandos with a 4-cycle debounce: load sequencing,
// bounce and glitch rejection, restart from LISTO, and reset interactions.
module tb_cargador_operandos;

  logic       clk;
  logic       rst;
  logic       btn;
  logic [2:0] sw;
  logic [2:0] a;
  logic [2:0] b;
  logic       listo;
  logic [1:0] estado;

  int vectors;
  int errors;

  // Packed observation {a, b, listo, estado}
  logic [8:0] obs;
  logic [8:0] exp_v;
  assign obs = {a, b, listo, estado};

  cargador_operandos #(
    .WIDTH(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .sw(sw),
    .a(a),
    .b(b),
    .listo(listo),
    .estado(estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 1'b1;
    sw  = 3'd7;
    for (int i = 0; i < 3; i++) begin
      step(1);
      exp_v = {3'd0, 3'd0, 1'b0, 2'd0};
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d] got a=%0d b=%0d listo=%0d estado=%0d want a=0 b=0 listo=0 estado=0",
                 i, a, b, listo, estado);
      end
    end
    rst = 1'b0;
    step(1);
    exp_v = {3'd0, 3'd0, 1'b0, 2'd0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_release got a=%0d b=%0d listo=%0d estado=%0d want all 0", a, b, listo, estado);
    end
    // Button held through reset release: one press after the debounce, loading A
    step(5);
    exp_v = {3'd0, 3'd0, 1'b0, 2'd0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL held_through_reset_early got a=%0d estado=%0d want a=0 estado=0", a, estado);
    end
    step(1);
    exp_v = {3'd7, 3'd0, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL held_through_reset_load got a=%0d b=%0d listo=%0d estado=%0d want a=7 b=0 listo=0 estado=1",
               a, b, listo, estado);
    end
    btn = 1'b0;
    step(20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    exp_v = {3'd0, 3'd0, 1'b0, 2'd0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_clean got a=%0d b=%0d listo=%0d estado=%0d want all 0", a, b, listo, estado);
    end
  endtask

  task automatic test_clean_load();
    sw  = 3'd5;
    btn = 1'b1;
    step(6);
    exp_v = {3'd0, 3'd0, 1'b0, 2'd0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL load_a_before_edge6 got a=%0d estado=%0d want a=0 estado=0", a, estado);
    end
    step(1);
    exp_v = {3'd5, 3'd0, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL load_a_edge6 got a=%0d b=%0d listo=%0d estado=%0d want a=5 b=0 listo=0 estado=1",
               a, b, listo, estado);
    end
    step(13);
    btn = 1'b0;
    step(20);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL load_a_release got a=%0d estado=%0d want a=5 estado=1", a, estado);
    end
    sw  = 3'd3;
    btn = 1'b1;
    step(7);
    exp_v = {3'd5, 3'd3, 1'b1, 2'd2};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL load_b got a=%0d b=%0d listo=%0d estado=%0d want a=5 b=3 listo=1 estado=2",
               a, b, listo, estado);
    end
    step(13);
    btn = 1'b0;
    step(20);
  endtask

  task automatic test_restart();
    sw  = 3'd2;
    btn = 1'b1;
    step(20);
    btn = 1'b0;
    step(20);
    exp_v = {3'd5, 3'd3, 1'b0, 2'd0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL restart got a=%0d b=%0d listo=%0d estado=%0d want a=5 b=3 listo=0 estado=0",
               a, b, listo, estado);
    end
    sw  = 3'd7;
    btn = 1'b1;
    step(20);
    btn = 1'b0;
    step(20);
    exp_v = {3'd7, 3'd3, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL restart_load_a got a=%0d b=%0d listo=%0d estado=%0d want a=7 b=3 listo=0 estado=1",
               a, b, listo, estado);
    end
  endtask

  task automatic test_glitch();
    sw  = 3'd6;
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    step(20);
    exp_v = {3'd7, 3'd3, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL glitch_3cyc got a=%0d b=%0d listo=%0d estado=%0d want a=7 b=3 listo=0 estado=1",
               a, b, listo, estado);
    end
    // Held press with a 3-cycle dip: exactly one press (loads B)
    sw  = 3'd4;
    btn = 1'b1;
    step(10);
    exp_v = {3'd7, 3'd4, 1'b1, 2'd2};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dip_load_b got a=%0d b=%0d listo=%0d estado=%0d want a=7 b=4 listo=1 estado=2",
               a, b, listo, estado);
    end
    btn = 1'b0;
    step(3);
    btn = 1'b1;
    step(10);
    btn = 1'b0;
    step(20);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dip_no_extra got a=%0d b=%0d listo=%0d estado=%0d want a=7 b=4 listo=1 estado=2",
               a, b, listo, estado);
    end
  endtask

  task automatic test_reset_mid_debounce();
    // From LISTO: one press to CARGA_A, one with sw=1 to load A and reach CARGA_B
    btn = 1'b1;
    step(20);
    btn = 1'b0;
    step(20);
    sw  = 3'd1;
    btn = 1'b1;
    step(20);
    btn = 1'b0;
    step(20);
    exp_v = {3'd1, 3'd4, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pre_mid_reset got a=%0d b=%0d listo=%0d estado=%0d want a=1 b=4 listo=0 estado=1",
               a, b, listo, estado);
    end
    sw  = 3'd2;
    btn = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_v = {3'd0, 3'd0, 1'b0, 2'd0};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset got a=%0d b=%0d listo=%0d estado=%0d want all 0", a, b, listo, estado);
    end
    step(6);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_wait got a=%0d estado=%0d want a=0 estado=0", a, estado);
    end
    step(1);
    exp_v = {3'd2, 3'd0, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_loads_a got a=%0d b=%0d listo=%0d estado=%0d want a=2 b=0 listo=0 estado=1",
               a, b, listo, estado);
    end
    btn = 1'b0;
    step(20);
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sw  = 3'd6;
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      btn = pat[i];
      step(1);
    end
    btn = 1'b1;
    step(10);
    exp_v = {3'd6, 3'd0, 1'b0, 2'd1};
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bounce_capture got a=%0d b=%0d listo=%0d estado=%0d want a=6 b=0 listo=0 estado=1",
               a, b, listo, estado);
    end
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    step(20);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bounce_release got a=%0d b=%0d listo=%0d estado=%0d want a=6 b=0 listo=0 estado=1",
               a, b, listo, estado);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    btn = 1'b0;
    sw  = 3'd0;
    step(2);
    test_reset();
    test_clean_load();
    test_restart();
    test_glitch();
    test_reset_mid_debounce();
    test_bounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
